// File: rtl/tone_pkg.sv
// Shared types, note table and period classifier for the tone decoder.
package tone_pkg;

  localparam int unsigned CNT_W    = 20;
  localparam int unsigned NOTE_CNT = 8;

  // Note periods in 100 MHz cycles, C4 (index 0) up to C5 (index 7).
  localparam logic [CNT_W-1:0] NOTE_PER [NOTE_CNT] = '{
    20'd382219, 20'd340530, 20'd303370, 20'd286344,
    20'd255102, 20'd227273, 20'd202478, 20'd191113
  };

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_LOCK} state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } match_t;

  // Table entries are >=5% apart, so at most one index can hit.
  // per_shift scales the whole table down (0 = real pitch).
  function automatic match_t note_match(input logic [CNT_W-1:0] p,
                                        input int unsigned      tol_shift,
                                        input int unsigned      per_shift);
    match_t                    m;
    logic [CNT_W-1:0]          per;
    logic [CNT_W-1:0]          tol;
    logic signed [CNT_W:0]     diff;
    logic signed [CNT_W:0]     mag;
    m = '0;
    for (int unsigned i = 0; i < NOTE_CNT; i++) begin
      per  = NOTE_PER[i] >> per_shift;
      tol  = per >> tol_shift;
      diff = $signed({1'b0, p}) - $signed({1'b0, per});
      mag  = (diff < 0) ? -diff : diff;
      if (mag <= $signed({1'b0, tol})) begin
        m.hit = 1'b1;
        m.idx = 3'(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic edge_o
);

  logic meta_q, sync_q, prev_q, edge_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      edge_q <= sync_q & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/tone_decoder.sv
// Measures the rising-to-rising period of TONE_IN and locks onto one of eight
// notes after two consecutive in-tolerance periods of the same note.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int unsigned TOL_SHIFT = 7,
  parameter int unsigned TIMEOUT   = 500_000,
  parameter int unsigned PER_SHIFT = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tone_in_i,
  output logic                valid_o,
  output logic [NOTE_CNT-1:0] note_o,
  output logic [CNT_W-1:0]    period_o,
  output logic                change_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic                edge_s;
  logic [CNT_W-1:0]    p_c;
  match_t              match_c;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          cand_q, cand_d;
  logic                valid_q, valid_d;
  logic [NOTE_CNT-1:0] note_q, note_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic                change_q, change_d;

  sync_edge u_sync_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (tone_in_i),
    .edge_o (edge_s)
  );

  assign p_c     = cnt_q + CNT_W'(1);
  assign match_c = note_match(p_c, TOL_SHIFT, PER_SHIFT);

  // Next-state logic: an edge always takes priority over the timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    valid_d  = valid_q;
    note_d   = note_q;
    period_d = period_q;

    if (edge_s) begin
      cnt_d = '0;
    end else if (cnt_q != TIMEOUT_C) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (edge_s) begin
      if (state_q != S_IDLE) period_d = p_c;
      unique case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: begin
          if (match_c.hit) begin
            state_d = S_MEAS;
            cand_d  = match_c.idx;
          end
        end
        S_MEAS: begin
          if (match_c.hit && match_c.idx == cand_q) begin
            state_d = S_LOCK;
            valid_d = 1'b1;
            note_d  = NOTE_CNT'(1) << cand_q;
          end else if (match_c.hit) begin
            cand_d = match_c.idx;
          end else begin
            state_d = S_ARM;
          end
        end
        S_LOCK: begin
          if (!(match_c.hit && match_c.idx == cand_q)) begin
            state_d = match_c.hit ? S_MEAS : S_ARM;
            cand_d  = match_c.hit ? match_c.idx : cand_q;
            valid_d = 1'b0;
            note_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (cnt_q == TIMEOUT_C) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      note_d  = '0;
    end

    change_d = ({valid_d, note_d} != {valid_q, note_q});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      valid_q  <= 1'b0;
      note_q   <= '0;
      period_q <= '0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      valid_q  <= valid_d;
      note_q   <= note_d;
      period_q <= period_d;
      change_q <= change_d;
    end
  end

  assign valid_o  = valid_q;
  assign note_o   = note_q;
  assign period_o = period_q;
  assign change_o = change_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder with the note table scaled down by 2^7 and a short timeout.
module tb_tone_decoder;

  localparam int unsigned TO_TB = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tone = 1'b0;
  logic        valid_o;
  logic [7:0]  note_o;
  logic [19:0] period_o;
  logic        change_o;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int unsigned chg_cnt = 0;
  int unsigned last_due = 0;

  typedef struct {
    string       name;
    int unsigned due;
    logic        v;
    logic [7:0]  n;
    logic [19:0] p;
    logic        ch;
  } exp_t;

  typedef struct {
    logic        rst_before;
    int unsigned gap;
    logic        v;
    logic [7:0]  n;
    logic [19:0] p;
    logic        ch;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  tone_decoder #(.TOL_SHIFT(7), .TIMEOUT(TO_TB), .PER_SHIFT(7)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tone_in_i (tone),
    .valid_o   (valid_o),
    .note_o    (note_o),
    .period_o  (period_o),
    .change_o  (change_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic push(input string name, input int unsigned due, input logic v,
                      input logic [7:0] n, input logic [19:0] p, input logic ch);
    exp_t e;
    e.name = name; e.due = due; e.v = v; e.n = n; e.p = p; e.ch = ch;
    sb.push_back(e);
  endtask

  // Pops each expectation on its due cycle and compares against the outputs.
  task automatic monitor();
    exp_t        e;
    logic [29:0] got, want;
    forever begin
      @(negedge clk);
      if (change_o) chg_cnt++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e    = sb.pop_front();
        got  = {valid_o, note_o, period_o, change_o};
        want = {e.v, e.n, e.p, e.ch};
        checks++;
        if (e.due != cyc || got !== want) begin
          errors++;
          $display("FAIL %s: got valid=%0b note=%h period=%0d change=%0b, want valid=%0b note=%h period=%0d change=%0b (cycle %0d due %0d)",
                   e.name, valid_o, note_o, period_o, change_o, e.v, e.n, e.p, e.ch, cyc, e.due);
        end
      end
    end
  endtask

  task automatic wait_drain();
    int unsigned t = 0;
    while (sb.size() > 0 && t < 10000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic reset_dut();
    wait_drain();
    @(posedge clk); #1;
    tone = 1'b0;
    rst  = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Rise gap cycles after the previous rise; outputs are due 4 cycles after the rise.
  task automatic send_rise(input string name, input int unsigned gap, input logic v,
                           input logic [7:0] n, input logic [19:0] p, input logic ch);
    repeat (gap / 2) @(posedge clk);
    #1 tone = 1'b0;
    repeat (gap - gap / 2) @(posedge clk);
    #1 tone = 1'b1;
    last_due = cyc + 4;
    push(name, last_due, v, n, p, ch);
  endtask

  task automatic add(input logic r, input int unsigned g, input logic v,
                     input logic [7:0] n, input logic [19:0] p, input logic ch);
    vec_t x;
    x.rst_before = r; x.gap = g; x.v = v; x.n = n; x.p = p; x.ch = ch;
    vecs.push_back(x);
  endtask

  initial begin
    int unsigned c0;

    // A4 clean lock, then stays locked
    add(1, 20,   0, 8'h00, 20'd0,    0);
    add(0, 1775, 0, 8'h00, 20'd1775, 0);
    add(0, 1775, 1, 8'h20, 20'd1775, 1);
    add(0, 1775, 1, 8'h20, 20'd1775, 0);
    // C5 at +tolerance locks
    add(1, 20,   0, 8'h00, 20'd0,    0);
    add(0, 1504, 0, 8'h00, 20'd1504, 0);
    add(0, 1504, 1, 8'h80, 20'd1504, 1);
    // C5 one past tolerance never locks
    add(1, 20,   0, 8'h00, 20'd0,    0);
    add(0, 1505, 0, 8'h00, 20'd1505, 0);
    add(0, 1505, 0, 8'h00, 20'd1505, 0);
    // C5 at -tolerance locks
    add(1, 20,   0, 8'h00, 20'd0,    0);
    add(0, 1482, 0, 8'h00, 20'd1482, 0);
    add(0, 1482, 1, 8'h80, 20'd1482, 1);
    // C4 lock, switch to E4, then an unmatched period
    add(1, 20,   0, 8'h00, 20'd0,    0);
    add(0, 2986, 0, 8'h00, 20'd2986, 0);
    add(0, 2986, 1, 8'h01, 20'd2986, 1);
    add(0, 2370, 0, 8'h00, 20'd2370, 1);
    add(0, 2370, 1, 8'h04, 20'd2370, 1);
    add(0, 1000, 0, 8'h00, 20'd1000, 1);
    add(0, 2370, 0, 8'h00, 20'd2370, 0);

    fork
      monitor();
    join_none

    // Reset and idle: no activity through a full timeout
    reset_dut();
    push("reset_state", cyc, 0, 8'h00, 20'd0, 0);
    c0 = chg_cnt;
    repeat (TO_TB + 10) @(posedge clk);
    #1;
    checks++;
    if (chg_cnt != c0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: got changes=%0d valid=%0b, want changes=0 valid=0",
               chg_cnt - c0, valid_o);
    end

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst_before) reset_dut();
      send_rise($sformatf("vec%0d", k), vecs[k].gap, vecs[k].v, vecs[k].n,
                vecs[k].p, vecs[k].ch);
    end

    // Signal loss: G4 lock, then TONE_IN held high
    reset_dut();
    send_rise("g4_r1", 20,   0, 8'h00, 20'd0,    0);
    send_rise("g4_r2", 1992, 0, 8'h00, 20'd1992, 0);
    send_rise("g4_r3", 1992, 1, 8'h10, 20'd1992, 1);
    push("loss_before", last_due + TO_TB,     1, 8'h10, 20'd1992, 0);
    push("loss_after",  last_due + TO_TB + 1, 0, 8'h00, 20'd1992, 1);
    wait_drain();

    // Reset mid-lock on D4, then relock from scratch
    reset_dut();
    send_rise("d4_r1", 20,   0, 8'h00, 20'd0,    0);
    send_rise("d4_r2", 2660, 0, 8'h00, 20'd2660, 0);
    send_rise("d4_r3", 2660, 1, 8'h02, 20'd2660, 1);
    wait_drain();
    repeat (100) @(posedge clk);
    #1 tone = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    push("mid_reset", cyc + 1, 0, 8'h00, 20'd0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_rise("d4_re1", 20,   0, 8'h00, 20'd0,    0);
    send_rise("d4_re2", 2660, 0, 8'h00, 20'd2660, 0);
    send_rise("d4_re3", 2660, 1, 8'h02, 20'd2660, 1);
    wait_drain();
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_decoder.md
# tone_decoder

Receive-side counterpart of the switch-driven tone generator. It samples an external square wave on a Pmod pin, measures the rising-to-rising period in CLK cycles, and classifies it against an 8-note table (C4..C5). It reports the recognised note as a one-hot code that mirrors the generator's one-hot switch selection, so a board can loop back its own TONES output, or read a second board's output, and confirm the selected note.

## Interface
Parameters:
- TOL_SHIFT, 7: match tolerance is NOTE_PER[i] >> TOL_SHIFT, about ±0.78%.
- TIMEOUT, 500_000: number of cycles without a rising edge before the block declares loss of signal (5 ms at 100 MHz).

Ports:
- CLK  in  1: 100 MHz system clock.
- RST  in  1: synchronous, active-high reset.
- TONE_IN  in  1: asynchronous square-wave input.
- VALID  out  1: high while a note is locked.
- NOTE  out  8: one-hot note; bit 0 = C4 ... bit 7 = C5. Zero when VALID=0.
- PERIOD  out  20: last measured period in CLK cycles.
- CHANGE  out  1: one-cycle pulse whenever {VALID, NOTE} changes value.

## Operation
- TONE_IN passes through a 2-flop synchronizer and a rising-edge detector, which produces strobe EDGE.
- Counter cnt (20 bits):
  - cleared to 0 on the cycle after EDGE;
  - otherwise increments, saturating at TIMEOUT.
  - Measured period P = cnt + 1 at EDGE.
- Note table NOTE_PER (cycles): 382219, 340530, 303370, 286344, 255102, 227273, 202478, 191113.
- Index i matches when |P − NOTE_PER[i]| ≤ NOTE_PER[i] >> TOL_SHIFT. The entries are spaced at least 5% apart, so at most one index matches. Comparison uses 21-bit signed arithmetic.
- FSM states: S_IDLE, S_ARM, S_MEAS, S_LOCK. The variable cand holds the candidate index.
  - S_IDLE: on EDGE → S_ARM.
  - S_ARM: on EDGE, if i matches → S_MEAS with cand=i; on no match, stay in S_ARM.
  - S_MEAS: on EDGE:
    - i == cand → S_LOCK, VALID=1, NOTE=1<<cand;
    - other match j → S_MEAS with cand=j;
    - no match → S_ARM.
  - S_LOCK: on EDGE:
    - i == cand → stay;
    - other match j → S_MEAS with cand=j, VALID=0, NOTE=0;
    - no match → S_ARM, VALID=0, NOTE=0.
- PERIOD updates on every EDGE taken in S_ARM, S_MEAS or S_LOCK. It holds its value otherwise.
- Timeout: when cnt == TIMEOUT with no EDGE, in any state → S_IDLE, VALID=0, NOTE=0. PERIOD is held.
- Simultaneous timeout and EDGE: EDGE wins. Because P = TIMEOUT+1 matches no table entry, the FSM goes to S_ARM (from S_ARM, S_MEAS or S_LOCK).
- A lock therefore requires two consecutive in-tolerance periods of the same note.

## Timing
- Reset values:
  - state = S_IDLE;
  - cnt = 0, cand = 0;
  - VALID = 0, NOTE = 0, PERIOD = 0, CHANGE = 0;
  - synchronizer and edge flops = 0.
- EDGE asserts 3 cycles after a TONE_IN rise meets setup, and is high for 1 cycle. The fixed latency cancels out of the P measurement.
- VALID, NOTE, PERIOD and state are registered and update on the cycle after EDGE. CHANGE pulses in that same cycle.
- Lock time from a clean signal: first EDGE, plus 2 periods, plus 1 cycle.
- RST asserted mid-measurement forces all of the above to reset values on the next edge of CLK, with no residue.
- TONE_IN held constant yields no EDGE and reaches the timeout after TIMEOUT cycles.

## Structure
- Package tone_pkg holds:
  - CNT_W = 20;
  - NOTE_CNT = 8;
  - NOTE_PER[0:7] table;
  - state_t enum {S_IDLE, S_ARM, S_MEAS, S_LOCK};
  - function note_match(P) returning {hit, idx[2:0]}.
- Sub-module sync_edge contains the 2-flop synchronizer plus a registered rising-edge pulse on CLK/RST. It is reusable for switch and button inputs.
- Top-level tone_decoder holds the counter, the FSM and the output registers.

## Test plan
- Reset and idle: RST for 5 cycles, TONE_IN=0 → VALID=0, NOTE=0, PERIOD=0. After TIMEOUT cycles still no CHANGE pulse.
- Clean A4: square wave, period 227273 cycles, 4 periods → VALID rises 1 cycle after the 3rd EDGE, NOTE=8'b0010_0000, PERIOD=227273, one CHANGE pulse.
- Tolerance edges: C5 period 191113+1493 → locks (NOTE=8'h80). Period 191113+1494 → stays unlocked; PERIOD=192607.
- Note switch: lock on C4 (382219), then switch to E4 (303370) → at the first E4 EDGE, VALID=0 and NOTE=0; at the second E4 EDGE, NOTE=8'b0000_0100 and VALID=1. Two CHANGE pulses.
- Signal loss: lock on G4, then hold TONE_IN=1 → exactly TIMEOUT cycles after the last EDGE (+1 register cycle), VALID=0, NOTE=0, PERIOD still 255102.
- Reset mid-lock: lock on D4, assert RST for 1 cycle → next cycle all outputs 0. Relock requires 3 fresh edges.
